// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and state encoding for the register file with scoreboard.
package reg_file_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_DEF = 31;
    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending bit per register; a claim beats a same-cycle clear.
// Lookups hide a pending bit that is being retired this cycle when bypass is enabled.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_add,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_add,
    input  logic [ADDR_W-1:0] rs_add,
    input  logic [ADDR_W-1:0] rt_add,
    output logic              rs_pending,
    output logic              rt_pending
);
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] bits;
    logic            rs_fwd, rt_fwd;

    // set is applied last so a claim overrides a retiring write to the same entry
    always_ff @(posedge clk) begin
        if (reset) begin
            bits <= '0;
        end else begin
            if (clr_en) bits[clr_add] <= 1'b0;
            if (set_en) bits[set_add] <= 1'b1;
        end
    end

    always_comb begin
        rs_fwd     = (BYPASS != 0) && clr_en && clr_add == rs_add && !(set_en && set_add == rs_add);
        rt_fwd     = (BYPASS != 0) && clr_en && clr_add == rt_add && !(set_en && set_add == rt_add);
        rs_pending = bits[rs_add] && !rs_fwd;
        rt_pending = bits[rt_add] && !rt_fwd;
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with hardwired-zero entry, write bypass and pending scoreboard.
// After reset every entry is cleared by a one-entry-per-cycle sweep reported on init_busy.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    input  logic [ADDR_W-1:0] rs_add,
    output logic [DATA_W-1:0] rs_value,
    output logic              rs_pending,
    input  logic [ADDR_W-1:0] rt_add,
    output logic [DATA_W-1:0] rt_value,
    output logic              rt_pending,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_add,
    input  logic [DATA_W-1:0] write_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_add
);
    localparam int              NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [NREG];
    logic              run, wr_ok, cl_ok, rs_sb, rt_sb;

    always_ff @(posedge clk) begin
        state <= reset ? RF_INIT : state_nxt;
    end

    always_comb begin
        state_nxt = (state == RF_INIT && cnt == '1) ? RF_RUN : state;
    end

    always_comb begin
        init_busy = state == RF_INIT;
        run       = state == RF_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (state == RF_INIT) cnt <= cnt + 1'b1;
    end

    assign wr_ok = run && write_enable && write_add != ZA;
    assign cl_ok = run && claim_en && claim_add != ZA;

    always_ff @(posedge clk) begin
        if (!reset && state == RF_INIT) mem[cnt] <= '0;
        else if (!reset && wr_ok) mem[write_add] <= write_data;
    end

    always_comb begin
        rs_value = (!run || rs_add == ZA) ? '0
                 : (BYPASS != 0 && wr_ok && write_add == rs_add) ? write_data : mem[rs_add];
        rt_value = (!run || rt_add == ZA) ? '0
                 : (BYPASS != 0 && wr_ok && write_add == rt_add) ? write_data : mem[rt_add];
        rs_pending = run && rs_sb;
        rt_pending = run && rt_sb;
    end

    reg_scoreboard #(
        .ADDR_W(ADDR_W),
        .BYPASS(BYPASS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (cl_ok),
        .set_add   (claim_add),
        .clr_en    (wr_ok),
        .clr_add   (write_add),
        .rs_add    (rs_add),
        .rt_add    (rt_add),
        .rs_pending(rs_sb),
        .rt_pending(rt_sb)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of sweep, bypass, zero register and scoreboard.
// A second instance with bypass disabled shares all inputs for the non-forwarding cases.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_busy, nb_busy;
    logic [4:0]  rs_add = '0, rt_add = '0, write_add = '0, claim_add = '0;
    logic [31:0] rs_value, rt_value, nb_rs_value, nb_rt_value;
    logic        rs_pending, rt_pending, nb_rs_pending, nb_rt_pending;
    logic        write_enable = 1'b0, claim_en = 1'b0;
    logic [31:0] write_data = '0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .reset(reset), .init_busy(init_busy),
        .rs_add(rs_add), .rs_value(rs_value), .rs_pending(rs_pending),
        .rt_add(rt_add), .rt_value(rt_value), .rt_pending(rt_pending),
        .write_enable(write_enable), .write_add(write_add), .write_data(write_data),
        .claim_en(claim_en), .claim_add(claim_add)
    );

    reg_file_sb #(.BYPASS(0)) nb (
        .clk(clk), .reset(reset), .init_busy(nb_busy),
        .rs_add(rs_add), .rs_value(nb_rs_value), .rs_pending(nb_rs_pending),
        .rt_add(rt_add), .rt_value(nb_rt_value), .rt_pending(nb_rt_pending),
        .write_enable(write_enable), .write_add(write_add), .write_data(write_data),
        .claim_en(claim_en), .claim_add(claim_add)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_sweep(input string tag);
        int n = 0;
        while (init_busy && n < 100) begin
            n++;
            tick();
        end
        check(tag, n, 32);
    endtask

    initial begin
        logic [31:0] acc;
        tick();
        tick();
        reset = 1'b0;
        count_sweep("sweep_len");
        check("nb_sweep_done", nb_busy, 0);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            rs_add = 5'(i);
            rt_add = 5'(31 - i);
            #1;
            acc |= rs_value | rt_value | 32'(rs_pending) | 32'(rt_pending);
        end
        check("sweep_all_zero", acc, 0);

        write_enable = 1; write_add = 5; write_data = 32'hDEADBEEF; rs_add = 5;
        #1;
        check("bypass_rs", rs_value, 32'hDEADBEEF);
        check("nobypass_rs", nb_rs_value, 0);
        tick();
        write_enable = 0;
        #1;
        check("stored_rs", rs_value, 32'hDEADBEEF);
        check("nb_stored_rs", nb_rs_value, 32'hDEADBEEF);

        write_enable = 1; write_add = 31; write_data = 32'h1234;
        claim_en = 1; claim_add = 31; rs_add = 31;
        #1;
        check("zero_bypass", rs_value, 0);
        tick();
        write_enable = 0; claim_en = 0;
        #1;
        check("zero_value", rs_value, 0);
        check("zero_pending", rs_pending, 0);

        claim_en = 1; claim_add = 7; rt_add = 7;
        #1;
        check("claim_not_yet", rt_pending, 0);
        tick();
        claim_en = 0;
        #1;
        check("claim_pending", rt_pending, 1);
        write_enable = 1; write_add = 7; write_data = 32'h77;
        #1;
        check("pending_fwd_clear", rt_pending, 0);
        check("nb_pending_held", nb_rt_pending, 1);
        tick();
        write_enable = 0;
        #1;
        check("pending_cleared", rt_pending, 0);
        check("r7_value", rt_value, 32'h77);
        claim_en = 1; write_enable = 1; write_add = 7; write_data = 32'h78;
        tick();
        claim_en = 0; write_enable = 0;
        #1;
        check("claim_wins", rt_pending, 1);
        check("claim_wins_nb", nb_rt_pending, 1);
        check("claim_wins_data", rt_value, 32'h78);

        write_enable = 1; write_add = 12; write_data = 32'hA5A5A5A5;
        tick();
        write_enable = 0; rs_add = 12; rt_add = 12;
        #1;
        check("dual_rs", rs_value, 32'hA5A5A5A5);
        check("dual_rt", rt_value, 32'hA5A5A5A5);
        check("dual_pend", {31'b0, rs_pending}, {31'b0, rt_pending});

        reset = 1;
        tick();
        reset = 0;
        write_enable = 1; write_add = 3; write_data = 32'hFFFF;
        claim_en = 1; claim_add = 4; rs_add = 3; rt_add = 4;
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy", init_busy, 1);
        check("init_rs_zero", rs_value, 0);
        check("init_rt_pend", rt_pending, 0);
        reset = 1;
        tick();
        reset = 0;
        count_sweep("resweep_len");
        write_enable = 0; claim_en = 0;
        #1;
        check("r3_lost", rs_value, 0);
        check("r4_not_claimed", rt_pending, 0);
        rs_add = 5; rt_add = 7;
        #1;
        check("r5_cleared", rs_value, 0);
        check("r7_pend_cleared", rt_pending, 0);
        rs_add = 12;
        #1;
        check("r12_cleared", rs_value, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
